// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 memory machine-cycle generator: state codes,
// cycle-type constants and default bus widths.
package z80_bus_pkg;

    localparam int unsigned DEF_AW = 16;
    localparam int unsigned DEF_DW = 8;

    // State register width and the wait counter width (FIXED_WAITS is 0..3)
    localparam int unsigned SW  = 3;
    localparam int unsigned WCW = 2;

    localparam logic [SW-1:0] ST_IDLE = 3'd0;
    localparam logic [SW-1:0] ST_T1   = 3'd1;
    localparam logic [SW-1:0] ST_T2   = 3'd2;
    localparam logic [SW-1:0] ST_TW   = 3'd3;
    localparam logic [SW-1:0] ST_T3   = 3'd4;

    localparam logic CYC_RD = 1'b0;
    localparam logic CYC_WR = 1'b1;

endpackage

// File: rtl/z80_mem_cycle_gen_if.sv
// Requester handshake plus VG8020 memory-bus signals of the Z80 cycle generator.
// master = the cycle generator, slave = requester and memory side.
interface z80_mem_cycle_gen_if
    import z80_bus_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          done;
    logic [DW-1:0] rdata;

    logic [AW-1:0] a;
    logic [DW-1:0] d_out;
    logic          d_oe;
    logic [DW-1:0] d_in;
    logic          nmreq;
    logic          nrd;
    logic          nwr;
    logic          nwait;

    modport master (
        input  req, we, addr, wdata, d_in, nwait,
        output ready, done, rdata, a, d_out, d_oe, nmreq, nrd, nwr
    );

    modport slave (
        output req, we, addr, wdata, d_in, nwait,
        input  ready, done, rdata, a, d_out, d_oe, nmreq, nrd, nwr
    );
endinterface

// File: rtl/z80_wait_ctr.sv
// Wait-state qualifier: fixed-wait down-counter plus optional nwait stretch.
// Z80_MEM_CYCLE_NWAIT_EN enables the nwait input.
module z80_wait_ctr
    import z80_bus_pkg::*;
#(
    parameter int unsigned FIXED_WAITS = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    input  logic nwait,
    output logic stay_c
);
`ifdef Z80_MEM_CYCLE_NWAIT_EN
    localparam logic NWAIT_EN = 1'b1;
`else
    localparam logic NWAIT_EN = 1'b0;
`endif

    logic [WCW-1:0] cnt;

    // Loaded while in T1 so the count is ready on entry to T2
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= WCW'(FIXED_WAITS);
        end else if (step && (cnt != '0)) begin
            cnt <= cnt - WCW'(1);
        end
    end

    // Fixed waits take priority; nwait is only considered once they run out
    assign stay_c = (cnt != '0) | (NWAIT_EN & ~nwait);

endmodule

// File: rtl/z80_mem_cycle_gen.sv
// Z80 memory read/write machine-cycle initiator (T1, T2, TW*, T3), one T-state per clk.
// Optional nwait stretching under Z80_MEM_CYCLE_NWAIT_EN.
module z80_mem_cycle_gen
    import z80_bus_pkg::*;
#(
    parameter int unsigned FIXED_WAITS = 0,
    parameter int unsigned AW          = DEF_AW,
    parameter int unsigned DW          = DEF_DW
) (
    input  logic                clk,
    input  logic                rst,
    z80_mem_cycle_gen_if.master bus
);
    logic [SW-1:0] state;
    logic [SW-1:0] state_nx;

    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;

    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;

    logic          ready_nx;
    logic          done_nx;
    logic          d_oe_nx;
    logic          nmreq_nx;
    logic          nrd_nx;
    logic          nwr_nx;
    logic [AW-1:0] a_nx;
    logic [DW-1:0] d_out_nx;
    logic [DW-1:0] rdata_nx;

    logic          stay_c;

    z80_wait_ctr #(
        .FIXED_WAITS (FIXED_WAITS)
    ) u_wait_ctr (
        .clk    (clk),
        .rst    (rst),
        .load   (state == ST_T1),
        .step   ((state == ST_T2) || (state == ST_TW)),
        .nwait  (bus.nwait),
        .stay_c (stay_c)
    );

    // Next state plus next-cycle bus outputs, so every strobe is registered
    always_comb begin
        state_nx  = state;
        cur_we    = lat_we;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        ready_nx  = 1'b0;
        done_nx   = 1'b0;
        d_oe_nx   = 1'b0;
        nmreq_nx  = 1'b1;
        nrd_nx    = 1'b1;
        nwr_nx    = 1'b1;
        a_nx      = bus.a;
        d_out_nx  = bus.d_out;
        rdata_nx  = bus.rdata;

        if (state == ST_IDLE) begin
            cur_we    = bus.we;
            cur_addr  = bus.addr;
            cur_wdata = bus.wdata;
        end

        case (state)
            ST_IDLE: if (bus.req) state_nx = ST_T1;
            ST_T1:   state_nx = ST_T2;
            ST_T2,
            ST_TW:   state_nx = stay_c ? ST_TW : ST_T3;
            ST_T3:   state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase

        case (state_nx)
            ST_T1: begin
                a_nx     = cur_addr;
                nmreq_nx = 1'b0;
                if (cur_we == CYC_WR) begin
                    d_out_nx = cur_wdata;
                    d_oe_nx  = 1'b1;
                end else begin
                    nrd_nx = 1'b0;
                end
            end
            ST_T2, ST_TW, ST_T3: begin
                nmreq_nx = 1'b0;
                if (cur_we == CYC_WR) begin
                    nwr_nx  = 1'b0;
                    d_oe_nx = 1'b1;
                end else begin
                    nrd_nx = 1'b0;
                end
            end
            default: begin
                ready_nx = 1'b1;
                if (state == ST_T3) begin
                    done_nx = 1'b1;
                    if (lat_we == CYC_RD) rdata_nx = bus.d_in;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat_we     <= CYC_RD;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            bus.ready  <= 1'b1;
            bus.done   <= 1'b0;
            bus.d_oe   <= 1'b0;
            bus.nmreq  <= 1'b1;
            bus.nrd    <= 1'b1;
            bus.nwr    <= 1'b1;
            bus.a      <= '0;
            bus.d_out  <= '0;
            bus.rdata  <= '0;
        end else begin
            state      <= state_nx;
            bus.ready  <= ready_nx;
            bus.done   <= done_nx;
            bus.d_oe   <= d_oe_nx;
            bus.nmreq  <= nmreq_nx;
            bus.nrd    <= nrd_nx;
            bus.nwr    <= nwr_nx;
            bus.a      <= a_nx;
            bus.d_out  <= d_out_nx;
            bus.rdata  <= rdata_nx;
            if ((state == ST_IDLE) && bus.req) begin
                lat_we    <= bus.we;
                lat_addr  <= bus.addr;
                lat_wdata <= bus.wdata;
            end
        end
    end

endmodule

// File: tb/tb_z80_mem_cycle_gen.sv
// Directed bench for z80_mem_cycle_gen: one instance with no fixed waits, one with a single fixed wait.
module tb_z80_mem_cycle_gen;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    z80_mem_cycle_gen_if #(.AW(16), .DW(8)) b0 ();
    z80_mem_cycle_gen_if #(.AW(16), .DW(8)) b1 ();

    z80_mem_cycle_gen #(.FIXED_WAITS(0), .AW(16), .DW(8)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    z80_mem_cycle_gen #(.FIXED_WAITS(1), .AW(16), .DW(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    // Strobe snapshot: {nmreq, nrd, nwr, d_oe, done}
    wire [4:0] s0 = {b0.nmreq, b0.nrd, b0.nwr, b0.d_oe, b0.done};
    wire [4:0] s1 = {b1.nmreq, b1.nrd, b1.nwr, b1.d_oe, b1.done};

    localparam logic [4:0] P_RD   = 5'b00100;
    localparam logic [4:0] P_WT1  = 5'b01110;
    localparam logic [4:0] P_WR   = 5'b01010;
    localparam logic [4:0] P_DONE = 5'b11101;
    localparam logic [4:0] P_IDLE = 5'b11100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one T-state; sampling happens 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] exp;
    logic [4:0] bb_tab [1:8];
    int         done_c;

    initial begin
        rst = 1'b1;
        b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0; b0.d_in = '0; b0.nwait = 1'b1;
        b1.req = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0; b1.d_in = '0; b1.nwait = 1'b1;
        step();
        step();
        chk("rst_strobes", s0, P_IDLE);
        chk("rst_ready", b0.ready, 1);
        chk("rst_a", b0.a, 0);
        chk("rst_dout", b0.d_out, 0);
        chk("rst_rdata", b0.rdata, 0);
        rst = 1'b0;
        step();

        // Read with zero waits: done in cycle 4
        b0.req = 1'b1; b0.we = 1'b0; b0.addr = 16'h8000; b0.d_in = 8'hA5;
        chk("rd_ready_c0", b0.ready, 1);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) begin
                b0.req = 1'b0;
                chk("rd_a_c1", b0.a, 16'h8000);
                chk("rd_ready_c1", b0.ready, 0);
            end
            exp = (c < 4) ? P_RD : (c == 4) ? P_DONE : P_IDLE;
            chk($sformatf("rd_c%0d", c), s0, exp);
        end
        chk("rd_rdata", b0.rdata, 8'hA5);
        chk("rd_a_hold", b0.a, 16'h8000);

        // Write with req held, then back-to-back read accepted in the done cycle
        bb_tab = '{P_WT1, P_WR, P_WR, P_DONE, P_RD, P_RD, P_RD, P_DONE};
        b0.req = 1'b1; b0.we = 1'b1; b0.addr = 16'hC123; b0.wdata = 8'h3C;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("bb_c%0d", c), s0, bb_tab[c]);
            if (c == 1) chk("wr_a", b0.a, 16'hC123);
            if (c <= 3) chk($sformatf("wr_dout_c%0d", c), b0.d_out, 8'h3C);
            if (c == 4) begin
                b0.we = 1'b0; b0.addr = 16'h1234; b0.d_in = 8'h5A;
            end
            if (c == 5) begin
                b0.req = 1'b0;
                chk("bb_rd_a", b0.a, 16'h1234);
            end
        end
        chk("bb_rdata", b0.rdata, 8'h5A);
        step();

`ifndef Z80_MEM_CYCLE_NWAIT_EN
        // nwait is ignored in this build
        b0.nwait = 1'b0;
        b0.req = 1'b1; b0.we = 1'b0; b0.addr = 16'h0042; b0.d_in = 8'h11;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) b0.req = 1'b0;
            if (c >= 3) chk($sformatf("nw_ign_c%0d", c), s0, (c == 4) ? P_DONE : P_RD);
        end
        chk("nw_ign_rdata", b0.rdata, 8'h11);
        b0.nwait = 1'b1;
        step();
`endif

        // One fixed wait; nwait low for two cycles only matters with the feature on
`ifdef Z80_MEM_CYCLE_NWAIT_EN
        done_c = 7;
`else
        done_c = 5;
`endif
        b1.req = 1'b1; b1.we = 1'b0; b1.addr = 16'h4000; b1.d_in = 8'h77;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) b1.req = 1'b0;
            if (c == 3) b1.nwait = 1'b0;
            if (c == 5) b1.nwait = 1'b1;
            exp = (c < done_c) ? P_RD : (c == done_c) ? P_DONE : P_IDLE;
            chk($sformatf("fw1_c%0d", c), s1, exp);
        end
        chk("fw1_rdata", b1.rdata, 8'h77);

        // Reset during TW of a write: no done pulse, bus released
        b1.req = 1'b1; b1.we = 1'b1; b1.addr = 16'h2222; b1.wdata = 8'h99;
        step();
        b1.req = 1'b0;
        step();
        step();
        chk("abort_tw", s1, P_WR);
        rst = 1'b1;
        step();
        chk("abort_strobes", s1, P_IDLE);
        chk("abort_ready", b1.ready, 1);
        chk("abort_a", b1.a, 0);
        chk("abort_dout", b1.d_out, 0);
        rst = 1'b0;
        step();
        chk("abort_no_done", s1, P_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
